vga_plot_arbiter: RTL and testbench

- Shares the single DESim pixel-write port (VGA_X, VGA_Y, VGA_COLOR, plot) among NREQ drawing engines, such as the maze renderer, sprite drawer and HUD.
- Includes a built-in full-screen clear sequencer, which takes priority over all requesters.
- Sits between the game's drawing engines and the top-level VGA outputs driven to the simulator.
- Accepts at most one pixel per clock and issues it one cycle later as a registered plot pulse.

---
 rtl/vga_plot_arbiter_if.sv | 22 ++
 rtl/vga_plot_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus shared by the drawing engines and the arbiter.
// Lane i of every packed vector belongs to requester i.
//   req_valid  requester has a pixel pending (held with its payload until ready)
//   req_ready  one-hot grant from the arbiter
//   req_x/y    packed coordinates, lane i at [i*XW +: XW] / [i*YW +: YW]
//   req_color  packed colours, lane i at [i*CW +: CW]
interface vga_plot_arbiter_if #(
    parameter int NREQ = 3,
    parameter int XW   = 10,
    parameter int YW   = 9,
    parameter int CW   = 24
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*YW-1:0] req_y;
    logic [NREQ*CW-1:0] req_color;

    // master = drawing engines, slave = arbiter
    modport master (output req_valid, req_x, req_y, req_color, input req_ready);
    modport slave  (input req_valid, req_x, req_y, req_color, output req_ready);
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port among NREQ drawing
// engines, with a built-in full-screen clear sequencer that pre-empts them.
// One pixel accepted per clock, issued one cycle later as a registered plot.
//   CLOCK_50, Resetn  clock / synchronous active-low reset
//   bus               requester handshake (vga_plot_arbiter_if.slave)
//   clr_start/color   start a clear with the given fill colour
//   clr_busy/done     clear in progress / last clear pixel issued
//   oob_drop          accepted pixel was off-screen and discarded
//   grant_id          last granted requester
//   VGA_X/Y/COLOR     pixel to draw, qualified by plot
module vga_plot_arbiter #(
    parameter int NREQ  = 3,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int CW    = 24,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  Resetn,
    vga_plot_arbiter_if.slave     bus,
    input  logic                  clr_start,
    input  logic [CW-1:0]         clr_color,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  oob_drop,
    output logic [GW-1:0]         grant_id,
    output logic [XW-1:0]         VGA_X,
    output logic [YW-1:0]         VGA_Y,
    output logic [CW-1:0]         VGA_COLOR,
    output logic                  plot
);
    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    // One extra bit so H_RES/V_RES fit even when they equal 2**XW / 2**YW
    localparam logic [XW:0]   LP_H    = (XW+1)'(H_RES);
    localparam logic [YW:0]   LP_V    = (YW+1)'(V_RES);
    localparam logic [XW-1:0] LP_XMAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] LP_YMAX = YW'(V_RES - 1);

    state_t          r_state, w_state_nxt;
    logic [GW-1:0]   r_ptr;
    logic [XW-1:0]   r_clr_x;
    logic [YW-1:0]   r_clr_y;
    logic [CW-1:0]   r_clr_color;

    logic            w_found;
    logic [GW-1:0]   w_idx;
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;
    logic            w_clr_go;
    logic            w_clr_end;
    logic [XW-1:0]   w_px;
    logic [YW-1:0]   w_py;
    logic [CW-1:0]   w_pc;
    logic            w_in_range;
    logic [GW-1:0]   w_ptr_nxt;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_idx   = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_found && bus.req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = GW'(j);
            end
        end
    end

    assign w_px       = bus.req_x[int'(w_idx)*XW +: XW];
    assign w_py       = bus.req_y[int'(w_idx)*YW +: YW];
    assign w_pc       = bus.req_color[int'(w_idx)*CW +: CW];
    assign w_in_range = ({1'b0, w_px} < LP_H) && ({1'b0, w_py} < LP_V);
    assign w_ptr_nxt  = (w_idx == GW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_clr_end  = (r_clr_x == LP_XMAX) && (r_clr_y == LP_YMAX);

    // Next-state and grant decode; clear start beats every requester.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_xfer      = 1'b0;
        w_clr_go    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_clr_go    = 1'b1;
                end else if (w_found) begin
                    w_ready[w_idx] = 1'b1;
                    w_xfer         = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_clr_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant is gated by reset so no requester believes a transfer happened.
    assign bus.req_ready = Resetn ? w_ready : '0;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_ptr       <= '0;
            r_clr_x     <= '0;
            r_clr_y     <= '0;
            r_clr_color <= '0;
            plot        <= 1'b0;
            VGA_X       <= '0;
            VGA_Y       <= '0;
            VGA_COLOR   <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            oob_drop    <= 1'b0;
            grant_id    <= '0;
        end else begin
            plot     <= 1'b0;
            clr_done <= 1'b0;
            oob_drop <= 1'b0;
            if (r_state == S_CLEAR) begin
                VGA_X     <= r_clr_x;
                VGA_Y     <= r_clr_y;
                VGA_COLOR <= r_clr_color;
                plot      <= 1'b1;
                if (w_clr_end) begin
                    clr_done <= 1'b1;
                    clr_busy <= 1'b0;
                end else if (r_clr_x == LP_XMAX) begin
                    r_clr_x <= '0;
                    r_clr_y <= r_clr_y + 1'b1;
                end else begin
                    r_clr_x <= r_clr_x + 1'b1;
                end
            end else if (w_clr_go) begin
                r_clr_color <= clr_color;
                r_clr_x     <= '0;
                r_clr_y     <= '0;
                clr_busy    <= 1'b1;
            end else if (w_xfer) begin
                // Off-screen pixels are consumed (handshake completes) but never drawn.
                grant_id <= w_idx;
                r_ptr    <= w_ptr_nxt;
                if (w_in_range) begin
                    VGA_X     <= w_px;
                    VGA_Y     <= w_py;
                    VGA_COLOR <= w_pc;
                    plot      <= 1'b1;
                end else begin
                    oob_drop <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter, run at a reduced resolution so a
// complete screen clear stays short. A spec-level model (pointer, pixels
// remaining in the clear, expected output registers) predicts every cycle.
module tb_vga_plot_arbiter;
    localparam int NREQ = 3;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int CW   = 24;
    localparam int H    = 40;
    localparam int V    = 30;
    localparam int GW   = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr_start = 1'b0;
    logic [CW-1:0] clr_color = '0;
    logic          clr_busy, clr_done, oob_drop, plot;
    logic [GW-1:0] grant_id;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_c;

    logic [XW-1:0] rx [NREQ];
    logic [YW-1:0] ry [NREQ];
    logic [CW-1:0] rc [NREQ];

    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW)) bus ();

    always_comb begin
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_color = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*XW +: XW]     = rx[i];
            bus.req_y[i*YW +: YW]     = ry[i];
            bus.req_color[i*CW +: CW] = rc[i];
        end
    end

    vga_plot_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .H_RES(H), .V_RES(V)) dut (
        .CLOCK_50 (clk),
        .Resetn   (rstn),
        .bus      (bus),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .oob_drop (oob_drop),
        .grant_id (grant_id),
        .VGA_X    (vga_x),
        .VGA_Y    (vga_y),
        .VGA_COLOR(vga_c),
        .plot     (plot)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int            m_ptr = 0;
    int            m_left = 0;   // clear pixels still to issue; 0 = not clearing
    int            m_gnt = -1;
    logic [CW-1:0] m_ccol = '0;
    logic          e_plot, e_busy, e_done, e_oob;
    logic [XW-1:0] e_x;
    logic [YW-1:0] e_y;
    logic [CW-1:0] e_col;
    logic [GW-1:0] e_gid;
    logic [NREQ-1:0] e_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs are set just after a falling edge; this checks the grant,
    // advances the model across the rising edge and checks the registers.
    task automatic cycle();
        #1;
        e_rdy = '0;
        m_gnt = -1;
        if (rstn && m_left == 0 && !clr_start)
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (m_gnt < 0 && bus.req_valid[j]) m_gnt = j;
            end
        if (m_gnt >= 0) e_rdy[m_gnt] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));

        if (!rstn) begin
            m_ptr = 0; m_left = 0;
            e_plot = 0; e_busy = 0; e_done = 0; e_oob = 0;
            e_x = '0; e_y = '0; e_col = '0; e_gid = '0;
        end else begin
            e_plot = 0; e_done = 0; e_oob = 0;
            if (m_left > 0) begin
                int p;
                p      = H*V - m_left;
                e_x    = XW'(p % H);
                e_y    = YW'(p / H);
                e_col  = m_ccol;
                e_plot = 1;
                m_left--;
                if (m_left == 0) begin
                    e_done = 1;
                    e_busy = 0;
                end
            end else if (clr_start) begin
                m_ccol = clr_color;
                m_left = H*V;
                e_busy = 1;
            end else if (m_gnt >= 0) begin
                e_gid = GW'(m_gnt);
                m_ptr = (m_gnt + 1) % NREQ;
                if (rx[m_gnt] < H && ry[m_gnt] < V) begin
                    e_plot = 1;
                    e_x    = rx[m_gnt];
                    e_y    = ry[m_gnt];
                    e_col  = rc[m_gnt];
                end else begin
                    e_oob = 1;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("plot",      64'(plot),     64'(e_plot));
        chk("VGA_X",     64'(vga_x),    64'(e_x));
        chk("VGA_Y",     64'(vga_y),    64'(e_y));
        chk("VGA_COLOR", 64'(vga_c),    64'(e_col));
        chk("clr_busy",  64'(clr_busy), 64'(e_busy));
        chk("clr_done",  64'(clr_done), 64'(e_done));
        chk("oob_drop",  64'(oob_drop), 64'(e_oob));
        chk("grant_id",  64'(grant_id), 64'(e_gid));
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_plot, n_done;
        rx[0] = 10'd1; ry[0] = 9'd1; rc[0] = 24'hFF0000;
        rx[1] = 10'd2; ry[1] = 9'd2; rc[1] = 24'h00FF00;
        rx[2] = 10'd3; ry[2] = 9'd3; rc[2] = 24'h0000FF;
        bus.req_valid = 3'b111;
        rstn = 1'b0;
        @(negedge clk);

        // Reset held with all requesters valid
        repeat (10) cycle();
        chk("rst_plot", 64'(plot), 64'd0);
        rstn = 1'b1;

        // All three valid: rotation 0,1,2,0,...
        cycle();
        chk("first_grant", 64'(grant_id), 64'd0);
        repeat (7) cycle();

        // Requester 1 streams 5 pixels back-to-back
        bus.req_valid = 3'b010;
        n_plot = 0;
        for (int i = 0; i < 5; i++) begin
            rx[1] = XW'($urandom_range(0, H-1));
            ry[1] = YW'($urandom_range(0, V-1));
            rc[1] = CW'($urandom);
            cycle();
            if (plot === 1'b1) n_plot++;
        end
        chk("stream_plots", 64'(n_plot), 64'd5);
        chk("stream_gid", 64'(grant_id), 64'd1);

        // Off-screen then bottom-right corner
        bus.req_valid = 3'b001;
        rx[0] = XW'(H); ry[0] = 9'd10;
        cycle();
        chk("oob_flag", 64'(oob_drop), 64'd1);
        rx[0] = XW'(H-1); ry[0] = YW'(V-1);
        cycle();
        chk("corner_plot", 64'(plot), 64'd1);
        bus.req_valid = '0;
        cycle();

        // Clear pre-empts requester 2, ignores restarts mid-clear and at the end
        bus.req_valid = 3'b100;
        rx[2] = 10'd7; ry[2] = 9'd8; rc[2] = 24'h123456;
        clr_start = 1'b1; clr_color = 24'h000000;
        cycle();
        clr_start = 1'b0;
        chk("clr_busy_on", 64'(clr_busy), 64'd1);
        n_plot = 0; n_done = 0;
        for (int c = 0; c < H*V + 4 && m_left > 0; c++) begin
            if (c == 100 || m_left == 1) begin
                clr_start = 1'b1;
                clr_color = 24'hFFFFFF;
            end
            cycle();
            clr_start = 1'b0;
            if (plot === 1'b1) n_plot++;
            if (clr_done === 1'b1) n_done++;
        end
        chk("clr_plots", 64'(n_plot), 64'(H*V));
        chk("clr_dones", 64'(n_done), 64'd1);
        chk("clr_busy_off", 64'(clr_busy), 64'd0);
        cycle();
        chk("post_clr_gid", 64'(grant_id), 64'd2);
        bus.req_valid = '0;

        // Reset during a clear
        bus.req_valid = 3'b001;
        cycle();
        bus.req_valid = '0;
        clr_start = 1'b1; clr_color = CW'($urandom);
        cycle();
        clr_start = 1'b0;
        repeat (5*H + 10) cycle();
        rstn = 1'b0;
        cycle();
        chk("rst_mid_plot", 64'(plot), 64'd0);
        chk("rst_mid_busy", 64'(clr_busy), 64'd0);
        rstn = 1'b1;
        bus.req_valid = 3'b111;
        cycle();
        chk("rst_mid_gid", 64'(grant_id), 64'd0);
        bus.req_valid = '0;

        // Random traffic: requesters hold payload until granted
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 2) != 0) begin
                    bus.req_valid[i] = 1'b1;
                    rx[i] = XW'($urandom_range(0, H+2));
                    ry[i] = YW'($urandom_range(0, V+2));
                    rc[i] = CW'($urandom);
                end
            clr_start = ($urandom_range(0, 299) == 0);
            clr_color = CW'($urandom);
            cycle();
            clr_start = 1'b0;
            if (m_gnt >= 0) bus.req_valid[m_gnt] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
